gelato_sm_controller: RTL

Per-SM front end that terminates the GPU-to-SM block-init channel and expands each thread block into a sequence of per-warp init transactions. It latches one block launch (pc, gridDim, blockDim, blockIdx), computes the block's thread count, and issues one warp record per cycle toward the split table and RF arbiter, which share a ready. It sits between the GPU-level block dispatcher and the SM's warp-side units.

---
 rtl/gelato_sm_controller.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/gelato_sm_controller.sv
// gelato_sm_controller: SM front end that latches one block launch and
// expands it into per-warp init records on a valid/ready channel.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   init_sm_valid              block-init strobe (honoured only when idle)
//   init_sm_pc                 kernel entry pc
//   init_sm_grid_dim/          int3 {z,y,x} launch geometry
//   init_sm_block_dim/
//   init_sm_block_idx
//   sm_busy                    high whenever not idle
//   warp_init_valid/ready      warp record handshake
//   warp_init_id               warp index within block
//   warp_init_workers          active threads in this warp
//   warp_init_pc/grid_dim/     latched launch fields, echoed per warp
//   block_dim/block_idx
//   block_done                 one-cycle pulse after last warp accepted
//   block_error                one-cycle pulse, block rejected
module gelato_sm_controller #(
  parameter  int WARP_SIZE = 32,
  parameter  int WARP_NUM  = 16,
  localparam int WARP_ID_W = $clog2(WARP_NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_sm_valid,
  input  logic [31:0]          init_sm_pc,
  input  logic [95:0]          init_sm_grid_dim,
  input  logic [95:0]          init_sm_block_dim,
  input  logic [95:0]          init_sm_block_idx,
  output logic                 sm_busy,
  output logic                 warp_init_valid,
  input  logic                 warp_init_ready,
  output logic [WARP_ID_W-1:0] warp_init_id,
  output logic [31:0]          warp_init_pc,
  output logic [31:0]          warp_init_workers,
  output logic [95:0]          warp_init_grid_dim,
  output logic [95:0]          warp_init_block_dim,
  output logic [95:0]          warp_init_block_idx,
  output logic                 block_done,
  output logic                 block_error
);

  localparam int MAX_THR = WARP_NUM * WARP_SIZE;
  localparam int CNT_W   = $clog2(MAX_THR + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_DONE,
    S_ERR
  } state_t;

  state_t               r_state;
  logic                 r_busy;
  logic                 r_valid;
  logic                 r_done;
  logic                 r_error;
  logic [WARP_ID_W-1:0] r_id;
  logic [CNT_W-1:0]     r_rem;
  logic [31:0]          r_workers;
  logic [31:0]          r_pc;
  logic [95:0]          r_gd;
  logic [95:0]          r_bd;
  logic [95:0]          r_bi;

  logic [95:0]          w_thr;
  logic                 w_bad;
  logic [CNT_W-1:0]     w_thr_n;
  logic [CNT_W-1:0]     w_wk_n;
  logic [CNT_W-1:0]     w_rem_nxt;
  logic                 w_last;
  logic                 w_fire;

  // Full-width product so oversized launches can never alias to small ones.
  assign w_thr = {64'd0, r_bd[31:0]}
               * {64'd0, r_bd[63:32]}
               * {64'd0, r_bd[95:64]};

  assign w_bad     = (w_thr == '0) || (w_thr > 96'(MAX_THR));
  assign w_thr_n   = w_thr[CNT_W-1:0];
  assign w_wk_n    = r_workers[CNT_W-1:0];
  assign w_rem_nxt = r_rem - w_wk_n;
  assign w_last    = (r_rem == w_wk_n);
  assign w_fire    = r_valid && warp_init_ready;

  function automatic logic [31:0] f_workers(
    input logic [CNT_W-1:0] n
  );
    if (n >= CNT_W'(WARP_SIZE))
      f_workers = 32'(WARP_SIZE);
    else
      f_workers = 32'(n);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_id      <= '0;
      r_rem     <= '0;
      r_workers <= '0;
      r_pc      <= '0;
      r_gd      <= '0;
      r_bd      <= '0;
      r_bi      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (init_sm_valid) begin
            r_pc    <= init_sm_pc;
            r_gd    <= init_sm_grid_dim;
            r_bd    <= init_sm_block_dim;
            r_bi    <= init_sm_block_idx;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (w_bad) begin
            r_error <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_id      <= '0;
            r_rem     <= w_thr_n;
            r_workers <= f_workers(w_thr_n);
            r_valid   <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_fire) begin
            if (w_last) begin
              // id stays on the final warp so it never wraps.
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_id      <= r_id + 1'b1;
              r_rem     <= w_rem_nxt;
              r_workers <= f_workers(w_rem_nxt);
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_error <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          r_error <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sm_busy             = r_busy;
  assign warp_init_valid     = r_valid;
  assign warp_init_id        = r_id;
  assign warp_init_pc        = r_pc;
  assign warp_init_workers   = r_workers;
  assign warp_init_grid_dim  = r_gd;
  assign warp_init_block_dim = r_bd;
  assign warp_init_block_idx = r_bi;
  assign block_done          = r_done;
  assign block_error         = r_error;

endmodule
